// File: rtl/scan_seq_if.sv
// scan_seq_if: beat stream, chain and status signals between scan sequencer and its neighbours
interface scan_seq_if #(
  parameter int NCHAIN = 4,
  parameter int PAT_W = 12,
  parameter int BW = 10
);
  logic start;
  logic [PAT_W-1:0] pat_num;
  logic si_vld;
  logic si_rdy;
  logic [NCHAIN-1:0] si_dat;
  logic [NCHAIN-1:0] si_exp;
  logic [NCHAIN-1:0] si_msk;
  logic scan_en;
  logic shift_en;
  logic capt_en;
  logic [NCHAIN-1:0] scan_in;
  logic [NCHAIN-1:0] scan_out;
  logic busy;
  logic done;
  logic fail;
  logic [15:0] err_cnt;
  logic [PAT_W-1:0] ff_pat;
  logic [BW-1:0] ff_beat;
  logic [NCHAIN-1:0] ff_chn;
  modport master (
    output start, pat_num, si_vld, si_dat, si_exp, si_msk, scan_out,
    input si_rdy, scan_en, shift_en, capt_en, scan_in, busy, done, fail, err_cnt, ff_pat, ff_beat, ff_chn
  );
  modport slave (
    input start, pat_num, si_vld, si_dat, si_exp, si_msk, scan_out,
    output si_rdy, scan_en, shift_en, capt_en, scan_in, busy, done, fail, err_cnt, ff_pat, ff_beat, ff_chn
  );
endinterface

// File: rtl/scan_seq_ctrl.sv
// scan_seq_ctrl: scan pattern sequencer with shift/capture/unload and response compare (SCAN_SEQ_DIAG_EN adds first-fail capture)
module scan_seq_ctrl #(
  parameter int NCHAIN = 4,
  parameter int CHAIN_LEN = 836,
  parameter int CAPT_CYC = 1,
  parameter int PAT_W = 12
) (
  input logic clk,
  input logic rst,
  scan_seq_if.slave sif
);
  localparam int BW = CHAIN_LEN > 1 ? $clog2(CHAIN_LEN) : 1;
  typedef enum logic [2:0] {IDLE, SHIFT, CAPT, UNLD, DONE} state_t;
  state_t state, nxt;
  logic [BW-1:0] beat;
  logic [1:0] cc;
  logic [PAT_W-1:0] pat_idx, pat_lat;
  logic shifting, acc, cmp, last_beat, last_capt, go;
  logic [NCHAIN-1:0] mm;
  logic [5:0] pc;
  logic [16:0] sum;
  logic fail_q;
  logic [15:0] err_q;
  assign go = state == IDLE && sif.start;
  assign shifting = state == SHIFT || state == UNLD;
  assign acc = shifting && sif.si_vld;
  assign cmp = acc && pat_idx != '0;
  assign last_beat = beat == BW'(CHAIN_LEN - 1);
  assign last_capt = cc == 2'(CAPT_CYC - 1);
  assign mm = (sif.scan_out ^ sif.si_exp) & sif.si_msk;
  assign sum = {1'b0, err_q} + 17'(pc);
  assign sif.si_rdy = shifting;
  assign sif.scan_en = shifting;
  assign sif.shift_en = acc;
  assign sif.scan_in = acc ? sif.si_dat : '0;
  assign sif.capt_en = state == CAPT;
  assign sif.busy = state != IDLE;
  assign sif.done = state == DONE;
  assign sif.fail = fail_q;
  assign sif.err_cnt = err_q;
  // number of mismatching chain bits on this beat
  always_comb begin
    pc = '0;
    for (int i = 0; i < NCHAIN; i++) pc = pc + 6'(mm[i]);
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // next state; the pattern that was just captured decides between another load and the final unload
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !sif.start ? IDLE : sif.pat_num == '0 ? DONE : SHIFT;
      SHIFT: nxt = acc && last_beat ? CAPT : SHIFT;
      CAPT: nxt = !last_capt ? CAPT : pat_idx + 1'b1 == pat_lat ? UNLD : SHIFT;
      UNLD: nxt = acc && last_beat ? DONE : UNLD;
      default: nxt = IDLE;
    endcase
  end
  // beat/capture/pattern counters and miscompare accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      beat <= '0;
      cc <= '0;
      pat_idx <= '0;
      pat_lat <= '0;
      fail_q <= 1'b0;
      err_q <= '0;
    end else if (go) begin
      beat <= '0;
      cc <= '0;
      pat_idx <= '0;
      pat_lat <= sif.pat_num;
      fail_q <= 1'b0;
      err_q <= '0;
    end else begin
      if (acc) beat <= last_beat ? '0 : beat + 1'b1;
      if (state == CAPT) cc <= last_capt ? '0 : cc + 1'b1;
      if (state == CAPT && last_capt) pat_idx <= pat_idx + 1'b1;
      if (cmp) fail_q <= fail_q | (|mm);
      if (cmp) err_q <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end
`ifdef SCAN_SEQ_DIAG_EN
  logic [PAT_W-1:0] ff_pat_q;
  logic [BW-1:0] ff_beat_q;
  logic [NCHAIN-1:0] ff_chn_q;
  // first miscompare snapshot, taken while fail is still clear
  always_ff @(posedge clk) begin
    if (rst || go) begin
      ff_pat_q <= '0;
      ff_beat_q <= '0;
      ff_chn_q <= '0;
    end else if (cmp && |mm && !fail_q) begin
      ff_pat_q <= pat_idx - 1'b1;
      ff_beat_q <= beat;
      ff_chn_q <= mm;
    end
  end
  assign sif.ff_pat = ff_pat_q;
  assign sif.ff_beat = ff_beat_q;
  assign sif.ff_chn = ff_chn_q;
`else
  assign sif.ff_pat = '0;
  assign sif.ff_beat = '0;
  assign sif.ff_chn = '0;
`endif
endmodule
